// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// keypad_matrix_scanner : ROWS x COLS matrix keypad scanner with frame-based
//                         debounce, binary key code and press/release pulses.
// Revision              : 1.0
// ============================================================================
module keypad_matrix_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 12500,
  parameter int DEBOUNCE = 4,
  localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   key_row,
  output logic [COLS-1:0]   key_col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              multi_key
);

  localparam int         CNT_W = $clog2(SCAN_DIV);
  localparam int         NBITS = ROWS * COLS;
  localparam logic [3:0] DEB4  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_t;

  logic [ROWS-1:0]   row_meta;
  logic [ROWS-1:0]   row_sync;
  logic [CNT_W-1:0]  div_cnt;
  logic              tick;
  logic              frame_end;
  logic [NBITS-1:0]  frame;
  logic [NBITS-1:0]  frame_full;
  logic [1:0]        ones;
  logic [CODE_W-1:0] hit_code;
  cls_t              frame_cls;
  logic [CODE_W-1:0] frame_code;
  cls_t              cand_cls;
  logic [CODE_W-1:0] cand_code;
  logic [3:0]        cand_cnt;
  logic              eval;
  cls_t              acc_cls;
  logic [CODE_W-1:0] acc_code;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  assign tick      = (div_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = tick & key_col[COLS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      key_col <= COLS'(1);
    end else if (tick) begin
      div_cnt <= '0;
      key_col <= {key_col[COLS-2:0], key_col[COLS-1]};
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (tick && key_col[c]) frame[c*ROWS +: ROWS] <= row_sync;
      end
    end
  end

  // Classification sees the last column straight from the synchroniser so the
  // frame is judged on the very tick that completes it.
  assign frame_full = {row_sync, frame[NBITS-ROWS-1:0]};

  always_comb begin
    ones     = 2'd0;
    hit_code = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (frame_full[c*ROWS + r]) begin
          if (ones != 2'd2) ones = ones + 2'd1;
          hit_code = CODE_W'(r * COLS + c);
        end
      end
    end
    frame_cls  = (ones == 2'd0) ? CLS_NONE : ((ones == 2'd1) ? CLS_SINGLE : CLS_MULTI);
    frame_code = (ones == 2'd1) ? hit_code : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_cls  <= CLS_NONE;
      cand_code <= '0;
      cand_cnt  <= 4'd0;
      eval      <= 1'b0;
    end else begin
      eval <= frame_end;
      if (frame_end) begin
        if (frame_cls == cand_cls && frame_code == cand_code) begin
          if (cand_cnt < DEB4) cand_cnt <= cand_cnt + 4'd1;
        end else begin
          cand_cls  <= frame_cls;
          cand_code <= frame_code;
          cand_cnt  <= 4'd1;
        end
      end
    end
  end

  assign accept = eval && (cand_cnt == DEB4) &&
                  ((cand_cls != acc_cls) || (cand_code != acc_code));

  // Accepted class acts as the output state; key_code only moves on a new single key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cls     <= CLS_NONE;
      acc_code    <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (accept) begin
        acc_cls     <= cand_cls;
        acc_code    <= cand_code;
        key_release <= (acc_cls == CLS_SINGLE);
        key_valid   <= (cand_cls == CLS_SINGLE);
        key_held    <= (cand_cls == CLS_SINGLE);
        multi_key   <= (cand_cls == CLS_MULTI);
        if (cand_cls == CLS_SINGLE) key_code <= cand_code;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_matrix_scanner : randomized frame-level checks against a keypad
//                            and debounce reference model.
// Revision                 : 1.0
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 3;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int NK       = ROWS * COLS;
  localparam int FRAME    = COLS * SCAN_DIV;
  localparam int COLS4    = 4;
  localparam int NK4      = ROWS * COLS4;
  localparam int LAT4     = (DEBOUNCE + 1) * COLS4 * SCAN_DIV + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;

  logic [ROWS-1:0] key_row;
  logic [COLS-1:0] key_col;
  logic [3:0]      key_code;
  logic            key_valid, key_release, key_held, multi_key;

  logic [ROWS-1:0]  key_row4;
  logic [COLS4-1:0] key_col4;
  logic [3:0]       key_code4;
  logic             key_valid4, key_release4, key_held4, multi_key4;

  logic [NK-1:0]   keys  = '0;
  logic [NK4-1:0]  keys4 = '0;
  logic            rand_en = 1'b0;
  logic [ROWS-1:0] rand_rows = '0;

  int n_vec = 0;
  int n_err = 0;
  int seen_valid = 0, seen_rel = 0, seen_rel4 = 0, seen_valid4 = 0;

  // reference model state
  int m_cand_kind = 0, m_cand_code = 0, m_cnt = 0;
  int m_acc_kind = 0, m_acc_code = 0;
  int m_code = 0, m_held = 0, m_multi = 0;
  int m_valid_tot = 0, m_rel_tot = 0;

  logic [NK-1:0] frames[$];

  always #5 clk = ~clk;

  keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col), .key_code(key_code),
    .key_valid(key_valid), .key_release(key_release), .key_held(key_held), .multi_key(multi_key)
  );

  keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS4), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut4 (
    .clk(clk), .rst(rst4), .key_row(key_row4), .key_col(key_col4), .key_code(key_code4),
    .key_valid(key_valid4), .key_release(key_release4), .key_held(key_held4), .multi_key(multi_key4)
  );

  // Physical keypad: a pressed key connects its column strobe to its row line.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS + c] && key_col[c]) key_row[r] = 1'b1;
    if (rand_en) key_row = rand_rows;
  end

  always_comb begin
    key_row4 = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS4; c++)
        if (keys4[r*COLS4 + c] && key_col4[c]) key_row4[r] = 1'b1;
  end

  always @(negedge clk) begin
    if (key_valid)    seen_valid++;
    if (key_release)  seen_rel++;
    if (key_valid4)   seen_valid4++;
    if (key_release4) seen_rel4++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NK-1:0] key_bit(input int idx);
    logic [NK-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  task automatic add_seg(input logic [NK-1:0] m, input int n);
    for (int i = 0; i < n; i++) frames.push_back(m);
  endtask

  // One scan frame seen by the model: classify by key count, debounce, accept.
  task automatic model_frame(input logic [NK-1:0] m, output int ev, output int er);
    int n, kind, code;
    n    = $countones(m);
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    code = 0;
    if (n == 1) for (int i = 0; i < NK; i++) if (m[i]) code = i;
    if (kind == m_cand_kind && code == m_cand_code) begin
      if (m_cnt < DEBOUNCE) m_cnt++;
    end else begin
      m_cand_kind = kind;
      m_cand_code = code;
      m_cnt       = 1;
    end
    ev = 0;
    er = 0;
    if (m_cnt == DEBOUNCE && (m_cand_kind != m_acc_kind || m_cand_code != m_acc_code)) begin
      er = (m_acc_kind == 1) ? 1 : 0;
      ev = (m_cand_kind == 1) ? 1 : 0;
      if (ev == 1) m_code = m_cand_code;
      m_held     = ev;
      m_multi    = (m_cand_kind == 2) ? 1 : 0;
      m_acc_kind = m_cand_kind;
      m_acc_code = m_cand_code;
    end
    m_valid_tot += ev;
    m_rel_tot   += er;
  endtask

  initial begin
    int ev, er, nfr, got, gcode;
    logic [NK-1:0] mk;

    // reset with random row noise
    rand_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      rand_rows = ROWS'($urandom);
    end
    @(posedge clk); #1;
    check_val("rst_col",     int'(key_col), 1);
    check_val("rst_code",    int'(key_code), 0);
    check_val("rst_valid",   int'(key_valid), 0);
    check_val("rst_release", int'(key_release), 0);
    check_val("rst_held",    int'(key_held), 0);
    check_val("rst_multi",   int'(multi_key), 0);

    @(negedge clk);
    rand_en = 1'b0;
    keys    = '0;
    rst     = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check_val("col_seq", int'(key_col), 1 << ((k / SCAN_DIV) % COLS));
    end

    // asynchronous reset mid-scan
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("abort_col", int'(key_col), 1);
    repeat (2) @(posedge clk);

    // directed scenarios followed by random segments
    add_seg(key_bit(7), 6);  add_seg('0, 6);
    add_seg(key_bit(0), 1);  add_seg('0, 1); add_seg(key_bit(0), 2); add_seg('0, 4);
    add_seg(key_bit(0) | key_bit(3), 5); add_seg(key_bit(0), 5); add_seg('0, 5);
    add_seg(key_bit(4), 5);  add_seg(key_bit(11), 5); add_seg('0, 5);
    for (int s = 0; s < 14; s++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      mk = '0;
      else if (sel < 8) mk = key_bit(int'($urandom_range(0, NK-1)));
      else              mk = key_bit(int'($urandom_range(0, NK-1))) | key_bit(int'($urandom_range(0, NK-1)));
      add_seg(mk, int'($urandom_range(1, 5)));
    end
    add_seg('0, DEBOUNCE + 1);

    nfr  = frames.size();
    keys = frames[0];
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      repeat ((f == 0) ? FRAME : FRAME - 1) @(posedge clk);
      #1;
      if (f + 1 < nfr) keys = frames[f+1];
      @(posedge clk); #1;
      model_frame(frames[f], ev, er);
      check_val("valid",   int'(key_valid), ev);
      check_val("release", int'(key_release), er);
      check_val("held",    int'(key_held), m_held);
      check_val("multi",   int'(multi_key), m_multi);
      check_val("code",    int'(key_code), m_code);
    end
    @(posedge clk); #1;
    check_val("valid_total",   seen_valid, m_valid_tot);
    check_val("release_total", seen_rel, m_rel_tot);

    // 4x4 variant: key 15 held across a reset
    keys4 = '0;
    keys4[NK4-1] = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    got = 0; gcode = 0;
    for (int i = 0; i < LAT4 && got == 0; i++) begin
      @(posedge clk); #1;
      if (key_valid4) begin got = 1; gcode = int'(key_code4); end
    end
    check_val("d4_valid", got, 1);
    check_val("d4_code",  gcode, 15);
    repeat (5) @(posedge clk); #1;
    check_val("d4_held", int'(key_held4), 1);

    @(negedge clk); #2;
    rst4 = 1'b1;
    #1;
    check_val("d4_rst_held",  int'(key_held4), 0);
    check_val("d4_rst_code",  int'(key_code4), 0);
    check_val("d4_rst_col",   int'(key_col4), 1);
    check_val("d4_rst_multi", int'(multi_key4), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    got = 0; gcode = 0;
    for (int i = 0; i < LAT4 && got == 0; i++) begin
      @(posedge clk); #1;
      if (key_valid4) begin got = 1; gcode = int'(key_code4); end
    end
    check_val("d4_revalid", got, 1);
    check_val("d4_recode",  gcode, 15);
    repeat (2) @(posedge clk); #1;
    check_val("d4_no_release", seen_rel4, 0);
    check_val("d4_valid_total", seen_valid4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
